// File: rtl/dest_demux.sv
// dest_demux: 2-entry skid buffer routing arbiter words to four purple FIFOs by destination.
// Optional per-destination push counters cnt0..cnt3 are built when DEMUX_COUNTERS_EN is defined.
module dest_demux #(
    parameter int BW = 6
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic [3:0]    state,
    input  logic          push_in,
    input  logic [BW-1:0] data_in,
    input  logic          almost_full0,
    input  logic          almost_full1,
    input  logic          almost_full2,
    input  logic          almost_full3,
    output logic          stall,
    output logic          push0,
    output logic          push1,
    output logic          push2,
    output logic          push3,
    output logic [BW-1:0] data_out,
    output logic          buf_empty,
`ifdef DEMUX_COUNTERS_EN
    output logic [4:0]    cnt0,
    output logic [4:0]    cnt1,
    output logic [4:0]    cnt2,
    output logic [4:0]    cnt3,
`endif
    output logic          overflow
);

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    logic [BW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [BW-1:0] head;
    logic [1:0]    dest;
    logic [3:0]    af;
    logic [3:0]    push_vec;
    logic [3:0]    push_q;
    logic          flush;
    logic          dispatch;
    logic          enqueue;
    logic          drop;

    assign af   = {almost_full3, almost_full2, almost_full1, almost_full0};
    assign head = mem[rd_ptr];
    assign dest = head[BW-1:BW-2];

    always_comb begin
        flush    = (state == ST_RESET);
        dispatch = (count != 2'd0) && (state == ST_ACTIVE) && !af[dest];
        // A pop on the same edge frees a slot for the incoming word
        enqueue  = push_in && !flush && ((count != 2'd2) || dispatch);
        drop     = push_in && !flush && (count == 2'd2) && !dispatch;
        push_vec = 4'b0000;
        if (dispatch) begin
            push_vec[dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enqueue) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            push_q   <= 4'b0000;
            data_out <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            push_q <= 4'b0000;
        end else begin
            push_q <= push_vec;
            if (dispatch) begin
                data_out <= head;
                rd_ptr   <= ~rd_ptr;
            end
            if (enqueue) begin
                wr_ptr <= ~wr_ptr;
            end
            count <= count + {1'b0, enqueue} - {1'b0, dispatch};
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign push0     = push_q[0];
    assign push1     = push_q[1];
    assign push2     = push_q[2];
    assign push3     = push_q[3];
    assign stall     = (count == 2'd2);
    assign buf_empty = (count == 2'd0);

`ifdef DEMUX_COUNTERS_EN
    logic [4:0] cnt [4];

    // Counts cycles with each registered push strobe high; wraps naturally
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 5'd0;
            end
        end else if (flush) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 5'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push_q[k]) begin
                    cnt[k] <= cnt[k] + 5'd1;
                end
            end
        end
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_dest_demux.sv
// Self-checking bench for dest_demux: queue-based reference model plus directed vectors.
// Counter checks are compiled in when DEMUX_COUNTERS_EN is defined.
module tb_dest_demux;

    localparam int BW = 6;
    localparam logic [3:0] RESET  = 4'b0001;
    localparam logic [3:0] INIT   = 4'b0010;
    localparam logic [3:0] IDLE   = 4'b0100;
    localparam logic [3:0] ACTIVE = 4'b1000;

    logic          clk     = 1'b0;
    logic          reset_L = 1'b0;
    logic [3:0]    state   = RESET;
    logic          push_in = 1'b0;
    logic [BW-1:0] data_in = '0;
    logic [3:0]    af      = 4'b0000;

    logic          stall;
    logic          push0, push1, push2, push3;
    logic [BW-1:0] data_out;
    logic          buf_empty;
    logic          overflow;
`ifdef DEMUX_COUNTERS_EN
    logic [4:0]    cnt0, cnt1, cnt2, cnt3;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    dest_demux #(.BW(BW)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .state       (state),
        .push_in     (push_in),
        .data_in     (data_in),
        .almost_full0(af[0]),
        .almost_full1(af[1]),
        .almost_full2(af[2]),
        .almost_full3(af[3]),
        .stall       (stall),
        .push0       (push0),
        .push1       (push1),
        .push2       (push2),
        .push3       (push3),
        .data_out    (data_out),
        .buf_empty   (buf_empty),
`ifdef DEMUX_COUNTERS_EN
        .cnt0        (cnt0),
        .cnt1        (cnt1),
        .cnt2        (cnt2),
        .cnt3        (cnt3),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a word queue of depth 2 and the registered outputs
    logic [BW-1:0] q[$];
    logic [3:0]    m_push = 4'b0000;
    logic [BW-1:0] m_data = '0;
    logic          m_ovf  = 1'b0;
    int            m_cnt [4] = '{0, 0, 0, 0};
    bit            m_disp;
    logic [1:0]    m_d;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q.delete();
            m_push = 4'b0000;
            m_data = '0;
            m_ovf  = 1'b0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (state == RESET) m_cnt[k] = 0;
                else if (m_push[k]) m_cnt[k] = (m_cnt[k] + 1) % 32;
            end
            m_disp = 0;
            m_d    = 2'd0;
            if (q.size() > 0) begin
                m_d    = q[0][BW-1:BW-2];
                m_disp = (state == ACTIVE) && !af[m_d];
            end
            m_push = 4'b0000;
            if (state == RESET) begin
                q.delete();
            end else begin
                if (m_disp) begin
                    m_push[m_d] = 1'b1;
                    m_data      = q.pop_front();
                end
                if (push_in) begin
                    if (q.size() < 2) q.push_back(data_in);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_push", {28'd0, push3, push2, push1, push0}, {28'd0, m_push});
            chk("m_data", {26'd0, data_out}, {26'd0, m_data});
            chk("m_stall", {31'd0, stall}, {31'd0, q.size() == 2});
            chk("m_empty", {31'd0, buf_empty}, {31'd0, q.size() == 0});
            chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef DEMUX_COUNTERS_EN
            chk("m_cnt0", {27'd0, cnt0}, m_cnt[0]);
            chk("m_cnt1", {27'd0, cnt1}, m_cnt[1]);
            chk("m_cnt2", {27'd0, cnt2}, m_cnt[2]);
            chk("m_cnt3", {27'd0, cnt3}, m_cnt[3]);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pushw(input logic [BW-1:0] w);
        push_in = 1'b1;
        data_in = w;
        step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_L = 1'b0;
        push_in = 1'b0;
        step();
        step();
        reset_L = 1'b1;
        step();
    endtask

    function automatic logic [31:0] pv();
        return {28'd0, push3, push2, push1, push0};
    endfunction

    logic [BW-1:0] words [4];

    initial begin
        words[0] = 6'b00_0001;
        words[1] = 6'b01_0010;
        words[2] = 6'b10_0011;
        words[3] = 6'b11_0100;

        @(posedge clk);
        cmp_en = 1;
        step();
        chk("reset buf_empty", {31'd0, buf_empty}, 32'd1);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset data_out", {26'd0, data_out}, 32'd0);
        step();

        // Single word after reset
        reset_L = 1'b1;
        state   = ACTIVE;
        pushw(6'b10_0101);
        chk("t1 buf_empty accepted", {31'd0, buf_empty}, 32'd0);
        push_in = 1'b0;
        step();
        chk("t1 push2", pv(), 32'b0100);
        chk("t1 data_out", {26'd0, data_out}, 32'h25);
        chk("t1 buf_empty", {31'd0, buf_empty}, 32'd1);
        step();
        chk("t1 push idle", pv(), 32'd0);

        // Back-to-back to all four destinations
        for (int i = 0; i < 4; i++) begin
            pushw(words[i]);
            if (i > 0) begin
                chk("t2 push order", pv(), 32'd1 << (i - 1));
                chk("t2 stall", {31'd0, stall}, 32'd0);
            end
        end
        push_in = 1'b0;
        step();
        chk("t2 push3", pv(), 32'b1000);
        chk("t2 data_out", {26'd0, data_out}, 32'h34);
        step();

        // Backpressure on destination 1
        af[1] = 1'b1;
        pushw(6'b01_0001);
        pushw(6'b01_0010);
        chk("t3 stall", {31'd0, stall}, 32'd1);
        pushw(6'b01_0011);
        chk("t3 overflow", {31'd0, overflow}, 32'd1);
        push_in = 1'b0;
        af[1]   = 1'b0;
        step();
        chk("t3 push1 a", pv(), 32'b0010);
        chk("t3 data a", {26'd0, data_out}, 32'h11);
        chk("t3 stall fell", {31'd0, stall}, 32'd0);
        step();
        chk("t3 push1 b", pv(), 32'b0010);
        chk("t3 data b", {26'd0, data_out}, 32'h12);
        chk("t3 empty", {31'd0, buf_empty}, 32'd1);
        step();
        chk("t3 no push", pv(), 32'd0);

        do_reset();
        chk("rst ovf cleared", {31'd0, overflow}, 32'd0);

        // Full buffer with simultaneous pop
        af[0] = 1'b1;
        pushw(6'h01);
        pushw(6'h02);
        chk("t4 full", {31'd0, stall}, 32'd1);
        af[0] = 1'b0;
        pushw(6'h03);
        chk("t4 push0", pv(), 32'b0001);
        chk("t4 data", {26'd0, data_out}, 32'h01);
        chk("t4 still full", {31'd0, stall}, 32'd1);
        chk("t4 no drop", {31'd0, overflow}, 32'd0);
        push_in = 1'b0;
        step();
        chk("t4 data 2", {26'd0, data_out}, 32'h02);
        step();
        chk("t4 data 3", {26'd0, data_out}, 32'h03);
        chk("t4 empty", {31'd0, buf_empty}, 32'd1);
        step();

        // State gating: IDLE holds, ACTIVE drains
        state = IDLE;
        pushw(6'h21);
        pushw(6'h22);
        push_in = 1'b0;
        step();
        chk("t5 idle no push", pv(), 32'd0);
        chk("t5 idle full", {31'd0, stall}, 32'd1);
        state = ACTIVE;
        step();
        chk("t5 drain a", {26'd0, data_out}, 32'h21);
        chk("t5 drain push2", pv(), 32'b0100);
        step();
        chk("t5 drain b", {26'd0, data_out}, 32'h22);
        step();

        // INIT accepts but does not dispatch
        state = INIT;
        pushw(6'h31);
        push_in = 1'b0;
        step();
        chk("t6 init no push", pv(), 32'd0);
        chk("t6 init held", {31'd0, buf_empty}, 32'd0);
        state = ACTIVE;
        step();
        chk("t6 push3", pv(), 32'b1000);
        chk("t6 data", {26'd0, data_out}, 32'h31);
        step();

        // Flush via state RESET keeps overflow
        state = IDLE;
        pushw(6'h23);
        pushw(6'h24);
        pushw(6'h25);
        chk("t7 ovf set", {31'd0, overflow}, 32'd1);
        state   = RESET;
        push_in = 1'b1;
        data_in = 6'h26;
        step();
        chk("t7 flushed", {31'd0, buf_empty}, 32'd1);
        chk("t7 ovf kept", {31'd0, overflow}, 32'd1);
        push_in = 1'b0;
        state   = ACTIVE;
        step();
        chk("t7 no push", pv(), 32'd0);
        step();

`ifdef DEMUX_COUNTERS_EN
        do_reset();
        for (int i = 0; i < 33; i++) begin
            pushw({2'b11, 4'(i)});
        end
        push_in = 1'b0;
        repeat (3) step();
        chk("t8 cnt3 wrap", {27'd0, cnt3}, 32'd1);
        chk("t8 cnt0", {27'd0, cnt0}, 32'd0);
        chk("t8 cnt1", {27'd0, cnt1}, 32'd0);
        chk("t8 cnt2", {27'd0, cnt2}, 32'd0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
